// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller for one cache (I or D).
// On a miss it stalls the pipeline, streams BLOCK_WORDS word reads to main
// memory (one per cycle), writes each returned word into the data array, and
// writes the tag together with the final data word.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  output logic                           fsm_busy,
  output logic                           mem_read_en,
  output logic [ADDR_W-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_index,
  output logic [15:0]                    cache_data,
  output logic                           write_tag_array,
  output logic [ADDR_W-1:0]              fill_block_addr
);

  // Word index width, counter width (one extra bit so the counter can reach
  // BLOCK_WORDS), and number of byte-offset bits inside a block.
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    req_count_reg;
  logic [CNT_W-1:0]    req_count_next;
  logic [CNT_W-1:0]    rcv_count_reg;
  logic [CNT_W-1:0]    rcv_count_next;
  logic [ADDR_W-1:0]   fill_block_addr_reg;
  logic [ADDR_W-1:0]   fill_block_addr_next;

  // Derived per-cycle conditions shared by next-state, datapath and outputs.
  logic                in_fill;
  logic                issue_req;
  logic                accept_word;
  logic                last_word;
  logic [ADDR_W-1:0]   miss_block_base;
  logic [ADDR_W-1:0]   req_offset;

  // Block base of the missing access: byte-offset bits cleared.
  assign miss_block_base = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Byte offset of the current request. The base has its offset bits cleared,
  // so OR-ing the offset in keeps every request inside the block (no carry
  // into the tag bits, e.g. block 0xFFF0 never wraps to 0x0000).
  assign req_offset = {{(ADDR_W - OFF_W){1'b0}}, req_count_reg[IDX_W-1:0], 1'b0};

  // Classify this cycle: request issue, word acceptance, final word.
  always_comb begin
    in_fill     = (state_reg == FILL);
    issue_req   = in_fill && !req_count_reg[IDX_W];
    accept_word = in_fill && memory_data_valid && !rcv_count_reg[IDX_W];
    last_word   = accept_word && (rcv_count_reg == LAST_WORD);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Fill bookkeeping registers: request/receive counters and latched block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_count_reg       <= '0;
      rcv_count_reg       <= '0;
      fill_block_addr_reg <= '0;
    end else begin
      req_count_reg       <= req_count_next;
      rcv_count_reg       <= rcv_count_next;
      fill_block_addr_reg <= fill_block_addr_next;
    end
  end

  // Next-state logic: a miss starts a fill; the final accepted word ends it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (miss_detected) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (last_word) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter and block-address updates. Misses seen during FILL are ignored
  // because the address is only captured in IDLE.
  always_comb begin
    req_count_next       = req_count_reg;
    rcv_count_next       = rcv_count_reg;
    fill_block_addr_next = fill_block_addr_reg;
    if (!in_fill) begin
      req_count_next = '0;
      rcv_count_next = '0;
      if (miss_detected) begin
        fill_block_addr_next = miss_block_base;
      end
    end else if (last_word) begin
      req_count_next = '0;
      rcv_count_next = '0;
    end else begin
      if (issue_req) begin
        req_count_next = req_count_reg + CNT_W'(1);
      end
      if (accept_word) begin
        rcv_count_next = rcv_count_reg + CNT_W'(1);
      end
    end
  end

  // Output logic. fsm_busy includes the miss cycle itself so the pipeline
  // stalls immediately; it is held low while reset is asserted even if a
  // miss is being reported.
  always_comb begin
    fsm_busy         = rst_n && (in_fill || miss_detected);
    mem_read_en      = issue_req;
    memory_address   = issue_req ? (fill_block_addr_reg | req_offset) : '0;
    write_data_array = accept_word;
    cache_word_index = accept_word ? rcv_count_reg[IDX_W-1:0] : '0;
    write_tag_array  = last_word;
  end

  // Returned words pass straight through to the data array write port.
  assign cache_data      = memory_data;
  assign fill_block_addr = fill_block_addr_reg;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized bench for cache_fill_fsm with a queue-based
// reference model and a variable-latency memory model.
module tb_cache_fill_fsm;

  localparam int BW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_detected = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic          fsm_busy;
  logic          mem_read_en;
  logic [AW-1:0] memory_address;
  logic          memory_data_valid = 1'b0;
  logic [15:0]   memory_data = '0;
  logic          write_data_array;
  logic [2:0]    cache_word_index;
  logic [15:0]   cache_data;
  logic          write_tag_array;
  logic [AW-1:0] fill_block_addr;

  always #5 clk = ~clk;

  cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .cache_word_index  (cache_word_index),
    .cache_data        (cache_data),
    .write_tag_array   (write_tag_array),
    .fill_block_addr   (fill_block_addr)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a fill is a list of block addresses still to be
  // requested and a list of words still to be written.
  bit            ref_fill = 0;
  logic [AW-1:0] ref_base = '0;
  logic [AW-1:0] req_q[$];
  logic [AW-1:0] wr_q[$];

  // Memory model: responses in request order after a fixed latency.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;
  rsp_t mq[$];
  int   lat      = 3;
  bit   gappy    = 0;
  bit   extra_en = 0;
  bit   spur     = 0;
  int   resp_cnt = 0;

  int fill_wr        = 0;
  int obs_wr         = 0;
  int obs_tag        = 0;
  int fill_start_cyc = 0;
  int last_tag_cyc   = -1;

  function automatic logic [15:0] mem_word(logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A3C;
  endfunction

  // One clock cycle: entered just after a rising edge with inputs set.
  task automatic tick();
    bit            e_rd;
    bit            e_wr;
    bit            e_tag;
    logic [AW-1:0] e_addr;
    memory_data_valid = 1'b0;
    memory_data       = 16'($urandom);
    if (mq.size() > 0 && mq[0].due <= cyc && (!gappy || $urandom_range(0, 2) != 0)) begin
      memory_data_valid = 1'b1;
      memory_data       = mq[0].data;
      void'(mq.pop_front());
      resp_cnt++;
    end else if (extra_en && mq.size() == 0 && resp_cnt == BW) begin
      memory_data_valid = 1'b1;
      extra_en          = 0;
    end else if (spur && !ref_fill) begin
      memory_data_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    e_rd   = ref_fill && req_q.size() > 0;
    e_addr = e_rd ? req_q[0] : 16'h0000;
    e_wr   = ref_fill && memory_data_valid && wr_q.size() > 0;
    e_tag  = e_wr && wr_q.size() == 1;
    chk("fsm_busy", fsm_busy, ref_fill || miss_detected);
    chk("mem_read_en", mem_read_en, e_rd);
    chk("memory_address", memory_address, e_addr);
    chk("write_data_array", write_data_array, e_wr);
    chk("write_tag_array", write_tag_array, e_tag);
    chk("fill_block_addr", fill_block_addr, ref_base);
    chk("cache_data", cache_data, memory_data);
    if (e_wr) begin
      chk("cache_word_index", cache_word_index, BW - wr_q.size());
      chk("word_data", cache_data, mem_word(wr_q[0]));
    end
    obs_wr  += int'(write_data_array);
    obs_tag += int'(write_tag_array);
    if (mem_read_en) mq.push_back('{due: cyc + lat, data: mem_word(memory_address)});
    @(posedge clk);
    if (ref_fill) begin
      if (e_rd) void'(req_q.pop_front());
      if (e_wr) begin
        void'(wr_q.pop_front());
        fill_wr++;
      end
      if (e_tag) begin
        ref_fill     = 0;
        last_tag_cyc = cyc;
      end
    end else if (miss_detected) begin
      ref_fill = 1;
      ref_base = miss_address & ~16'h000F;
      req_q.delete();
      wr_q.delete();
      for (int i = 0; i < BW; i++) begin
        req_q.push_back(ref_base + 16'(2 * i));
        wr_q.push_back(ref_base + 16'(2 * i));
      end
      fill_wr  = 0;
      resp_cnt = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic run_to_end(bit noise);
    int n = 0;
    while (ref_fill && n < 300) begin
      if (noise) begin
        miss_detected = ($urandom_range(0, 3) == 0);
        miss_address  = 16'($urandom);
      end
      tick();
      n++;
    end
    miss_detected = 1'b0;
  endtask

  task automatic do_fill(logic [15:0] addr, int l, bit g, bit noise, bit extra);
    lat = l; gappy = g; extra_en = extra;
    obs_wr = 0; obs_tag = 0;
    fill_start_cyc = cyc;
    miss_detected = 1'b1;
    miss_address  = addr;
    tick();
    miss_detected = 1'b0;
    run_to_end(noise);
    for (int i = 0; i < 4; i++) tick();
    $display("fill addr=0x%04h lat=%0d gaps=%0d noise=%0d extra=%0d writes=%0d tags=%0d",
             addr, l, g, noise, extra, obs_wr, obs_tag);
    chk("fill_writes", obs_wr, BW);
    chk("fill_tags", obs_tag, 1);
  endtask

  // Assert reset between edges and check every control output drops at once.
  task automatic reset_mid();
    miss_detected     = 1'b1;
    miss_address      = 16'($urandom);
    memory_data_valid = 1'b1;
    rst_n             = 1'b0;
    #1;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_read_en", mem_read_en, 0);
    chk("rst_address", memory_address, 0);
    chk("rst_write", write_data_array, 0);
    chk("rst_tag", write_tag_array, 0);
    chk("rst_block", fill_block_addr, 0);
    ref_fill = 0;
    ref_base = '0;
    req_q.delete();
    wr_q.delete();
    mq.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rst_busy_held", fsm_busy, 0);
    chk("rst_read_en_held", mem_read_en, 0);
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    rst_n             = 1'b1;
    $display("reset pulse at cycle %0d", cyc);
  endtask

  initial begin
    logic [15:0] a2;
    // Power-on reset with a miss and valid asserted.
    miss_detected     = 1'b1;
    memory_data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("por_busy", fsm_busy, 0);
    chk("por_read_en", mem_read_en, 0);
    chk("por_write", write_data_array, 0);
    chk("por_tag", write_tag_array, 0);
    chk("por_block", fill_block_addr, 0);
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    rst_n             = 1'b1;

    // Spurious valids while idle.
    spur = 1; obs_wr = 0;
    for (int i = 0; i < 8; i++) tick();
    spur = 0;
    $display("idle spurious valids: writes=%0d", obs_wr);
    chk("idle_writes", obs_wr, 0);

    // Basic fill, 4-cycle memory.
    do_fill(16'h1236, 3, 0, 0, 0);
    chk("basic_tag_cycle", last_tag_cyc - fill_start_cyc, 11);
    chk("basic_block", fill_block_addr, 16'h1230);

    // Top-of-memory block.
    do_fill(16'hFFFF, 3, 0, 0, 0);
    chk("wrap_block", fill_block_addr, 16'hFFF0);

    // Misses with other addresses during the fill.
    do_fill(16'h2468, 2, 0, 1, 0);

    // Gappy responses plus one extra valid.
    do_fill(16'h0A5A, 3, 1, 0, 1);

    // Reset after three data writes, then a fresh fill.
    lat = 3; gappy = 0;
    miss_detected = 1'b1;
    miss_address  = 16'h7777;
    tick();
    miss_detected = 1'b0;
    for (int n = 0; n < 100 && fill_wr < 3; n++) tick();
    chk("pre_reset_writes", fill_wr, 3);
    reset_mid();
    do_fill(16'h0040, 3, 0, 0, 0);

    // Back-to-back misses: miss held through the end of the fill.
    lat = 2; gappy = 0;
    a2 = 16'hBEE5;
    obs_wr = 0; obs_tag = 0;
    miss_detected = 1'b1;
    miss_address  = 16'h3000;
    tick();
    for (int n = 0; n < 300 && ref_fill; n++) begin
      miss_address = a2;
      tick();
    end
    tick();
    miss_detected = 1'b0;
    chk("b2b_refill", ref_fill, 1);
    run_to_end(0);
    for (int i = 0; i < 4; i++) tick();
    $display("back-to-back fills: writes=%0d tags=%0d block=0x%04h", obs_wr, obs_tag, fill_block_addr);
    chk("b2b_writes", obs_wr, 2 * BW);
    chk("b2b_tags", obs_tag, 2);
    chk("b2b_block", fill_block_addr, 16'hBEE0);

    // Randomized fills.
    for (int t = 0; t < 12; t++) begin
      do_fill(16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller between the pipeline's instruction/data cache and the multi-cycle main memory. On a cache miss it stalls the pipeline and issues one memory read per cycle for the 8 words of the missing 16-byte block. It writes each returned word into the cache data array, then writes the tag once the whole block is in. One instance serves the I-cache and one serves the D-cache. The IF and MEM stages consume `fsm_busy` as their stall.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block. Must be a power of 2.
- ADDR_W, 16: byte-address width.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, active-low, asynchronous.
- miss_detected, input, 1: cache lookup missed this cycle.
- miss_address, input, ADDR_W: byte address of the missing access.
- fsm_busy, output, 1: fill in progress; the pipeline stalls while this is high.
- mem_read_en, output, 1: read request to memory this cycle.
- memory_address, output, ADDR_W: byte address of the current request.
- memory_data_valid, input, 1: memory is returning a word this cycle (responses in request order).
- memory_data, input, 16: returned word.
- write_data_array, output, 1: write `cache_data` at `cache_word_index`.
- cache_word_index, output, log2(BLOCK_WORDS): word offset within the block.
- cache_data, output, 16: word to write; equals `memory_data` (combinational).
- write_tag_array, output, 1: write tag/valid for `fill_block_addr`.
- fill_block_addr, output, ADDR_W: latched block base address.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE.
  - Request counter and receive counter go to 0; `fill_block_addr` goes to 0.
  - All control outputs are 0, including while reset is held.
- States:
  - IDLE -> FILL when `miss_detected` = 1 at a rising edge.
  - FILL -> IDLE at the edge that ends the cycle in which the BLOCK_WORDS-th valid word is accepted.
- `fsm_busy` = (state == FILL) | (state == IDLE & miss_detected). This stalls the pipeline in the miss cycle itself.
- On IDLE->FILL, latch `fill_block_addr` = miss_address with the low log2(2*BLOCK_WORDS) bits cleared. Changes to `miss_address` during FILL are ignored.
- Requests, in FILL:
  - `mem_read_en` = 1 while the request count is below BLOCK_WORDS.
  - `memory_address` = fill_block_addr + 2*req_count.
  - `req_count` increments each requesting cycle.
  - Exactly BLOCK_WORDS requests are issued, one per cycle, starting in the first FILL cycle.
  - When `mem_read_en` = 0, `memory_address` = 0.
- Address arithmetic is ADDR_W wide and never carries past the block. Block 0xFFF0 requests 0xFFF0 through 0xFFFE.
- Responses:
  - In FILL with `memory_data_valid` = 1 and rcv_count < BLOCK_WORDS: `write_data_array` = 1, `cache_word_index` = rcv_count, and rcv_count increments.
  - The FSM does not depend on memory latency; it only counts valids.
  - A valid can arrive in the same cycle as a request.
- `write_tag_array` pulses for exactly one cycle, the same cycle as the final data write.
- Ignored events:
  - `memory_data_valid` while IDLE.
  - Valids beyond BLOCK_WORDS.
  - `miss_detected` while in FILL.
- Leaving FILL clears both counters. A `miss_detected` in the first IDLE cycle after a fill starts a new fill normally.
- Reset during FILL aborts the fill immediately. No tag write occurs, and after reset release the FSM is in IDLE with `fsm_busy` = 0.

Test Plan:
- Basic fill with a 4-cycle-latency memory model:
  - Stimulus: `miss_detected` = 1 with `miss_address` = 0x1236 at cycle 0.
  - Cycle 0: `fsm_busy` = 1 combinationally.
  - Cycles 1-8: requests to 0x1230, 0x1232, ... 0x123E.
  - Cycles 4-11: data writes at indices 0-7.
  - Cycle 11: `write_tag_array` = 1 and `fill_block_addr` = 0x1230.
  - Cycle 12: `fsm_busy` = 0.
- Wrap boundary: miss at 0xFFFF -> `fill_block_addr` = 0xFFF0, last request 0xFFFE, no requests to 0x0000.
- Spurious events:
  - `memory_data_valid` pulsed while IDLE -> no writes, `fsm_busy` stays 0.
  - A second `miss_detected` in mid-fill with a different address -> request stream and latched address unchanged.
- Irregular memory: responses with gaps (valid pattern 1,0,1,1,0,0,...) and a 9th extra valid -> exactly 8 data writes with indices 0-7, a single tag pulse on the 8th write, the extra valid ignored.
- Reset mid-fill: rst_n low after 3 data writes -> all outputs 0 asynchronously. After release, a miss at 0x0040 -> fresh fill from 0x0040 with index starting at 0.
- Back-to-back misses: `miss_detected` held high across the fill end -> IDLE for exactly 1 cycle (`fsm_busy` still 1 via the miss term), then a new fill with a newly latched address.
